// File: rtl/lsu_byte_split.sv
// lsu_byte_split: load/store unit in front of the 256x8 data memory.
// Accepts one CPU request at a time, performs one or two byte accesses
// (16-bit accesses are split into two sequential bytes) and returns a
// single-cycle response carrying the assembled load data.
module lsu_byte_split #(
  parameter bit BIG_ENDIAN = 1'b0,
  parameter bit ZERO_EXT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        busy,
  output logic [7:0]  DataAddress,
  output logic        ReadMem,
  output logic        WriteMem,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Request fields captured at accept; req_* is ignored for the rest of the access.
  logic        lat_write;
  logic        lat_wide;
  logic [7:0]  lat_addr;
  logic [15:0] lat_wdata;

  // First byte returned by a wide load, held until the second byte arrives.
  logic [7:0]  first_byte;
  logic [15:0] rdata_nxt;
  logic        accept;

  // Narrow load result: zero- or sign-extension of the single byte.
  function automatic logic [15:0] extend_byte(input logic [7:0] b);
    logic signed [7:0]  b_s;
    logic signed [15:0] b_ext;
    b_s   = signed'(b);
    b_ext = 16'(b_s);
    if (ZERO_EXT)
      return {8'h00, b};
    else
      return b_ext;
  endfunction

  // Byte written in B0: narrow stores always use the low byte; wide stores
  // start with the high byte when big-endian.
  function automatic logic [7:0] first_wbyte(input logic wide, input logic [15:0] d);
    if (wide && BIG_ENDIAN)
      return d[15:8];
    else
      return d[7:0];
  endfunction

  // Byte written in B1 (wide stores only).
  function automatic logic [7:0] second_wbyte(input logic [15:0] d);
    if (BIG_ENDIAN)
      return d[7:0];
    else
      return d[15:8];
  endfunction

  // Wide load assembly from the byte read in B0 and the byte read in B1.
  function automatic logic [15:0] join_bytes(input logic [7:0] b_first, input logic [7:0] b_second);
    if (BIG_ENDIAN)
      return {b_first, b_second};
    else
      return {b_second, b_first};
  endfunction

  assign accept = req_valid && (state == IDLE);

  // Next-state and output decode; memory outputs depend only on state and latched fields.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    resp_valid  = 1'b0;
    DataAddress = 8'h00;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = 8'h00;
    rdata_nxt   = resp_rdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid)
          state_nxt = B0;
      end
      B0: begin
        DataAddress = lat_addr;
        ReadMem     = !lat_write;
        WriteMem    = lat_write;
        DataIn      = lat_write ? first_wbyte(lat_wide, lat_wdata) : 8'h00;
        if (lat_wide) begin
          state_nxt = B1;
        end else begin
          state_nxt = RESP;
          rdata_nxt = lat_write ? 16'h0000 : extend_byte(DataOut);
        end
      end
      B1: begin
        DataAddress = lat_addr + 8'd1;
        ReadMem     = !lat_write;
        WriteMem    = lat_write;
        DataIn      = lat_write ? second_wbyte(lat_wdata) : 8'h00;
        state_nxt   = RESP;
        rdata_nxt   = lat_write ? 16'h0000 : join_bytes(first_byte, DataOut);
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Capture request fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_wide  <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 16'h0000;
    end else if (accept) begin
      lat_write <= req_write;
      lat_wide  <= req_wide;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Hold the first byte of a wide load until B1 completes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      first_byte <= 8'h00;
    else if (state == B0 && !lat_write)
      first_byte <= DataOut;
  end

  // Response data is updated on entry to RESP and held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      resp_rdata <= 16'h0000;
    else
      resp_rdata <= rdata_nxt;
  end

  // Memory strobes never overlap and only appear in the byte states.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(ReadMem && WriteMem));
  a_strobe_state: assert property (@(posedge clk) disable iff (!rst_n)
    (ReadMem || WriteMem) |-> (state == B0 || state == B1));

endmodule

// File: tb/tb_lsu_byte_split.sv
// tb_lsu_byte_split: directed vectors against two instances
// (little-endian/zero-extend and big-endian/sign-extend), each with its own
// 256x8 memory model.
module tb_lsu_byte_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;

  logic        req_ready_le, resp_valid_le, busy_le, ReadMem_le, WriteMem_le;
  logic [15:0] resp_rdata_le;
  logic [7:0]  DataAddress_le, DataIn_le, DataOut_le;
  logic        req_ready_be, resp_valid_be, busy_be, ReadMem_be, WriteMem_be;
  logic [15:0] resp_rdata_be;
  logic [7:0]  DataAddress_be, DataIn_be, DataOut_be;

  logic [7:0]  mem_le [256];
  logic [7:0]  mem_be [256];

  int          n_vec = 0;
  int          n_bad = 0;

  // strobe log (little-endian instance) and event counters
  int          alog_n = 0;
  logic [7:0]  alog_a [256];
  logic [7:0]  alog_d [256];
  logic        alog_w [256];
  int          resp_cnt = 0;
  int          excl_bad = 0;

  always #5 clk = ~clk;

  lsu_byte_split u_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_le),
    .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_le), .resp_rdata(resp_rdata_le), .busy(busy_le),
    .DataAddress(DataAddress_le), .ReadMem(ReadMem_le), .WriteMem(WriteMem_le),
    .DataIn(DataIn_le), .DataOut(DataOut_le)
  );

  lsu_byte_split #(.BIG_ENDIAN(1'b1), .ZERO_EXT(1'b0)) u_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_be),
    .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_be), .resp_rdata(resp_rdata_be), .busy(busy_be),
    .DataAddress(DataAddress_be), .ReadMem(ReadMem_be), .WriteMem(WriteMem_be),
    .DataIn(DataIn_be), .DataOut(DataOut_be)
  );

  assign DataOut_le = mem_le[DataAddress_le];
  assign DataOut_be = mem_be[DataAddress_be];

  always @(posedge clk) begin
    if (WriteMem_le) mem_le[DataAddress_le] = DataIn_le;
    if (WriteMem_be) mem_be[DataAddress_be] = DataIn_be;
  end

  always @(posedge clk) begin
    if (ReadMem_le || WriteMem_le) begin
      alog_a[alog_n % 256] = DataAddress_le;
      alog_d[alog_n % 256] = DataIn_le;
      alog_w[alog_n % 256] = WriteMem_le;
      alog_n++;
    end
    if (resp_valid_le) resp_cnt++;
    if ((ReadMem_le && WriteMem_le) || (ReadMem_be && WriteMem_be)) excl_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; checks latency, response data and the strobe log.
  task automatic acc(input string nm, input logic w, input logic wd, input logic [7:0] a,
                     input logic [15:0] d, input logic [15:0] e_le, input logic [15:0] e_be);
    int base;
    int edges;
    logic [7:0] a1;
    a1 = a + 8'd1;
    chk({nm, " ready"}, 32'(req_ready_le), 32'd1);
    req_valid = 1'b1; req_write = w; req_wide = wd; req_addr = a; req_wdata = d;
    base = alog_n;
    step();
    req_valid = 1'b0; req_write = ~w; req_wide = ~wd; req_addr = ~a; req_wdata = ~d;
    edges = 1;
    while (!resp_valid_le && edges < 8) begin
      step();
      edges++;
    end
    chk({nm, " latency"}, 32'(edges), wd ? 32'd3 : 32'd2);
    chk({nm, " rdata_le"}, 32'(resp_rdata_le), 32'(e_le));
    chk({nm, " rdata_be"}, 32'(resp_rdata_be), 32'(e_be));
    chk({nm, " vld_be"}, 32'(resp_valid_be), 32'd1);
    chk({nm, " nbytes"}, 32'(alog_n - base), wd ? 32'd2 : 32'd1);
    chk({nm, " addr0"}, 32'(alog_a[base % 256]), 32'(a));
    chk({nm, " kind0"}, 32'(alog_w[base % 256]), 32'(w));
    if (w) chk({nm, " din0"}, 32'(alog_d[base % 256]), 32'(d[7:0]));
    if (wd) begin
      chk({nm, " addr1"}, 32'(alog_a[(base + 1) % 256]), 32'(a1));
      if (w) chk({nm, " din1"}, 32'(alog_d[(base + 1) % 256]), 32'(d[15:8]));
    end
    step();
    chk({nm, " pulse"}, 32'(resp_valid_le), 32'd0);
    chk({nm, " back_idle"}, 32'(req_ready_le), 32'd1);
  endtask

  logic [7:0]  hs_addr [9] = '{8'h10, 8'h55, 8'h66, 8'h20, 8'h55, 8'h66, 8'h21, 8'h55, 8'h66};
  logic        hs_rdy  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        hs_vld  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] hs_le   [9] = '{16'h0, 16'h0, 16'h00A5, 16'h0, 16'h0, 16'h00EF, 16'h0, 16'h0, 16'h00BE};
  logic [15:0] hs_be   [9] = '{16'h0, 16'h0, 16'hFFA5, 16'h0, 16'h0, 16'hFFBE, 16'h0, 16'h0, 16'hFFEF};

  initial begin
    int rc;
    // reset state
    repeat (2) step();
    chk("rst ready", 32'(req_ready_le), 32'd1);
    chk("rst outs_le", {9'd0, resp_valid_le, busy_le, ReadMem_le, WriteMem_le, DataAddress_le, DataIn_le}, 32'd0);
    chk("rst outs_be", {9'd0, resp_valid_be, busy_be, ReadMem_be, WriteMem_be, DataAddress_be, DataIn_be}, 32'd0);
    chk("rst rdata", {resp_rdata_le, resp_rdata_be}, 32'd0);
    rst_n = 1'b1;
    step();

    // narrow store then load, sign/zero extension
    acc("st8_10", 1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 16'h0000);
    chk("mem_le10", 32'(mem_le[8'h10]), 32'h A5);
    acc("ld8_10", 1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 16'hFFA5);

    // wide access, both byte orders
    acc("st16_20", 1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 16'h0000);
    chk("mem_le20", {mem_le[8'h20], mem_le[8'h21]}, 32'h EFBE);
    chk("mem_be20", {mem_be[8'h20], mem_be[8'h21]}, 32'h BEEF);
    acc("ld16_20", 1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 16'hBEEF);

    // address wrap 0xFF -> 0x00
    acc("st16_ff", 1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 16'h0000);
    chk("mem_le_wrap", {mem_le[8'hFF], mem_le[8'h00]}, 32'h 3412);
    chk("mem_be_wrap", {mem_be[8'hFF], mem_be[8'h00]}, 32'h 1234);
    acc("ld16_ff", 1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 16'h1234);

    // positive byte: sign extension gives zero upper half
    acc("st8_41", 1'b1, 1'b0, 8'h41, 16'hFF77, 16'h0000, 16'h0000);
    acc("ld8_41", 1'b0, 1'b0, 8'h41, 16'h0000, 16'h0077, 16'h0077);

    // back-to-back narrow loads with req_valid held and addr churning
    rc = resp_cnt;
    req_write = 1'b0; req_wide = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req_valid = (i < 7);
      req_addr  = hs_addr[i];
      chk($sformatf("hs ready%0d", i), 32'(req_ready_le), 32'(hs_rdy[i]));
      chk($sformatf("hs vld%0d", i), 32'(resp_valid_le), 32'(hs_vld[i]));
      if (hs_vld[i]) begin
        chk($sformatf("hs rd_le%0d", i), 32'(resp_rdata_le), 32'(hs_le[i]));
        chk($sformatf("hs rd_be%0d", i), 32'(resp_rdata_be), 32'(hs_be[i]));
      end
      step();
    end
    req_valid = 1'b0;
    chk("hs count", 32'(resp_cnt - rc), 32'd3);
    step();

    // reset during B1 of a wide store
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1; req_addr = 8'h40; req_wdata = 16'hCAFE;
    step();
    req_valid = 1'b0;
    step();
    rc = resp_cnt;
    chk("abort in_b1", {30'd0, busy_le, WriteMem_le}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort outs_le", {9'd0, resp_valid_le, busy_le, ReadMem_le, WriteMem_le, DataAddress_le, DataIn_le}, 32'd0);
    chk("abort outs_be", {9'd0, resp_valid_be, busy_be, ReadMem_be, WriteMem_be, DataAddress_be, DataIn_be}, 32'd0);
    chk("abort ready", {30'd0, req_ready_le, req_ready_be}, 32'd3);
    chk("abort rdata", {resp_rdata_le, resp_rdata_be}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("abort no_resp", 32'(resp_cnt - rc), 32'd0);
    chk("abort mem_le", {mem_le[8'h40], mem_le[8'h41]}, 32'h FE77);
    chk("abort mem_be", {mem_be[8'h40], mem_be[8'h41]}, 32'h CA77);

    // idle quiescence
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("idle%0d", i),
          {10'd0, busy_le, ReadMem_le, WriteMem_le, DataAddress_le, busy_be, ReadMem_be, WriteMem_be, DataAddress_be},
          32'd0);
      step();
    end

    chk("strobe excl", 32'(excl_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
